// File: rtl/buf_const_pkg.sv
// Shared definitions for the burst pattern source: generator modes, FSM states
// and the next-word function used by the generator.
package buf_const_pkg;

  // Widest word the generator function handles; callers zero-extend and truncate.
  localparam int MAX_W = 64;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INCR  = 2'd1;
  localparam logic [1:0] MODE_ROTL  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bits at and above 'width' in the result are don't-care; the caller keeps the low 'width' bits.
  function automatic logic [MAX_W-1:0] gen_next(input logic [MAX_W-1:0] word,
                                                input logic [1:0]       mode,
                                                input int               width);
    logic [MAX_W-1:0] r;
    r = word;
    case (mode)
      MODE_INCR: r = word + MAX_W'(1);
      MODE_ROTL: r = (word << 1) | MAX_W'(word[width-1]);
      default:   r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/buf_const_stream_skid_buf.sv
// Two-entry valid/ready buffer. Entry e0 is always the head and drives out_data.
// A push is accepted when full as long as the head is popped on the same edge.
module skid_buf #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] e0;
  logic [WIDTH-1:0] e1;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  assign in_ready  = (cnt != 2'd2) || out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = e0;
  assign level     = cnt;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Entry storage and occupancy; flush empties the buffer and clears the word.
  always_ff @(posedge clk) begin
    if (flush) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= in_data;
          else             e1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= in_data;
          end else begin
            e0 <= e1;
            e1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/buf_const_stream.sv
// Burst pattern source: generates WIDTH-bit words from a seed and streams them
// through a two-entry skid buffer.
//
//   state | meaning
//   IDLE  | waiting for start; load updates the seed
//   RUN   | generating and pushing one word per edge while the buffer accepts
//   DRAIN | no more pushes; waiting for buffered words to leave, then pulse done
module buf_const_stream
  import buf_const_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int VALUE = 1,
  parameter int COUNT = 4,
  parameter int MODE  = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             busy,
  output logic             done
);

  localparam int               CW       = (COUNT < 1) ? 1 : $clog2(COUNT + 1);
  localparam logic [CW-1:0]    COUNT_C  = COUNT[CW-1:0];
  localparam logic [WIDTH-1:0] SEED_RST = VALUE[WIDTH-1:0];
  localparam logic [1:0]       MODE_SEL = MODE[1:0];

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] gen_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_inc;
  logic             done_q;

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             in_ready;
  logic [1:0]       level;
  logic             pop;
  logic             drain_empty;
  logic [MAX_W-1:0] push_ext;
  logic [MAX_W-1:0] gen_nx_ext;
  logic [WIDTH-1:0] gen_nx;

  assign cnt_inc     = cnt_q + CW'(1);
  assign pop         = O_valid && O_ready;
  assign drain_empty = (level == 2'd0) || ((level == 2'd1) && pop);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

  // Widen the pushed word so the shared package function can advance it.
  always_comb begin
    push_ext = '0;
    push_ext[WIDTH-1:0] = push_data;
    gen_nx_ext = gen_next(push_ext, MODE_SEL, WIDTH);
    gen_nx = gen_nx_ext[WIDTH-1:0];
  end

  // Next state and push decision; a start with load pushes load_val directly.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = gen_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          push      = 1'b1;
          push_data = load ? load_val : seed_q;
          state_d   = (COUNT == 1) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (in_ready) begin
          push = 1'b1;
          if ((COUNT != 0) && (cnt_inc == COUNT_C)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, seed, generator and word counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      seed_q  <= SEED_RST;
      gen_q   <= SEED_RST;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN) && (state_d == IDLE);
      if ((state_q == IDLE) && load) seed_q <= load_val;
      if (push) begin
        gen_q <= gen_nx;
        cnt_q <= (state_q == IDLE) ? CW'(1) : cnt_inc;
      end
    end
  end

  skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk       (CLK),
    .flush     (RESET),
    .in_valid  (push),
    .in_ready  (in_ready),
    .in_data   (push_data),
    .out_valid (O_valid),
    .out_ready (O_ready),
    .out_data  (O),
    .level     (level)
  );

endmodule

// File: tb/tb_buf_const_stream.sv
// Directed bench: four instances cover CONST/COUNT=4, INCR/COUNT=3,
// ROTL/COUNT=4 and continuous CONST, all WIDTH=2.
module tb_buf_const_stream;

  logic       clk = 1'b0;
  logic       rst[4];
  logic       start[4];
  logic       stop[4];
  logic       load[4];
  logic [1:0] lv[4];
  logic [1:0] o[4];
  logic       ov[4];
  logic       ordy[4];
  logic       busy[4];
  logic       done[4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  buf_const_stream #(.WIDTH(2), .VALUE(1), .COUNT(4), .MODE(0)) dut_const (
    .CLK(clk), .RESET(rst[0]), .start(start[0]), .stop(stop[0]), .load(load[0]),
    .load_val(lv[0]), .O(o[0]), .O_valid(ov[0]), .O_ready(ordy[0]), .busy(busy[0]), .done(done[0]));

  buf_const_stream #(.WIDTH(2), .VALUE(3), .COUNT(3), .MODE(1)) dut_incr (
    .CLK(clk), .RESET(rst[1]), .start(start[1]), .stop(stop[1]), .load(load[1]),
    .load_val(lv[1]), .O(o[1]), .O_valid(ov[1]), .O_ready(ordy[1]), .busy(busy[1]), .done(done[1]));

  buf_const_stream #(.WIDTH(2), .VALUE(1), .COUNT(4), .MODE(2)) dut_rotl (
    .CLK(clk), .RESET(rst[2]), .start(start[2]), .stop(stop[2]), .load(load[2]),
    .load_val(lv[2]), .O(o[2]), .O_valid(ov[2]), .O_ready(ordy[2]), .busy(busy[2]), .done(done[2]));

  buf_const_stream #(.WIDTH(2), .VALUE(1), .COUNT(0), .MODE(0)) dut_cont (
    .CLK(clk), .RESET(rst[3]), .start(start[3]), .stop(stop[3]), .load(load[3]),
    .load_val(lv[3]), .O(o[3]), .O_valid(ov[3]), .O_ready(ordy[3]), .busy(busy[3]), .done(done[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check valid, and the word when a word is expected.
  task automatic chk_word(input int d, input string tag, input logic ev, input logic [1:0] eo);
    chk({tag, ".valid"}, 32'(ov[d]), 32'(ev));
    if (ev) chk({tag, ".O"}, 32'(o[d]), 32'(eo));
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; stop[d] = 1'b0; load[d] = 1'b0;
      lv[d] = 2'd0; ordy[d] = 1'b1;
    end
    tick();
    tick();
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;

    // Reset state
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst%0d.valid", d), 32'(ov[d]), 0);
      chk($sformatf("rst%0d.O", d), 32'(o[d]), 0);
      chk($sformatf("rst%0d.busy", d), 32'(busy[d]), 0);
      chk($sformatf("rst%0d.done", d), 32'(done[d]), 0);
    end

    // 1: CONST burst of four 1s, then done pulse
    pulse_start(0);
    chk_word(0, "t1.w0", 1'b1, 2'd1);
    chk("t1.busy", 32'(busy[0]), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_word(0, $sformatf("t1.w%0d", i), 1'b1, 2'd1);
      chk($sformatf("t1.done_w%0d", i), 32'(done[0]), 0);
    end
    tick();
    chk_word(0, "t1.end", 1'b0, 2'd0);
    chk("t1.busy_end", 32'(busy[0]), 0);
    chk("t1.done", 32'(done[0]), 1);
    tick();
    chk("t1.done_clr", 32'(done[0]), 0);

    // 2: INCR 3,0,1 with wrap; second start on the done cycle repeats it
    pulse_start(1);
    chk_word(1, "t2.w0", 1'b1, 2'd3);
    tick(); chk_word(1, "t2.w1", 1'b1, 2'd0);
    tick(); chk_word(1, "t2.w2", 1'b1, 2'd1);
    tick();
    chk_word(1, "t2.end", 1'b0, 2'd0);
    chk("t2.done", 32'(done[1]), 1);
    pulse_start(1);
    chk_word(1, "t2.r0", 1'b1, 2'd3);
    chk("t2.r_busy", 32'(busy[1]), 1);
    chk("t2.r_done", 32'(done[1]), 0);
    tick(); chk_word(1, "t2.r1", 1'b1, 2'd0);
    tick(); chk_word(1, "t2.r2", 1'b1, 2'd1);
    tick(); chk("t2.r_donepulse", 32'(done[1]), 1);
    tick(); chk("t2.r_doneclr", 32'(done[1]), 0);

    // 3: ROTL 1,2,1,2 with a three-cycle stall holding the second word
    pulse_start(2);
    chk_word(2, "t3.w0", 1'b1, 2'd1);
    tick(); chk_word(2, "t3.w1", 1'b1, 2'd2);
    ordy[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_word(2, $sformatf("t3.hold%0d", i), 1'b1, 2'd2);
    end
    ordy[2] = 1'b1;
    tick(); chk_word(2, "t3.w2", 1'b1, 2'd1);
    tick(); chk_word(2, "t3.w3", 1'b1, 2'd2);
    tick();
    chk_word(2, "t3.end", 1'b0, 2'd0);
    chk("t3.done", 32'(done[2]), 1);

    // 4: continuous CONST with load+start; stop drains then done
    load[3] = 1'b1; lv[3] = 2'd2;
    pulse_start(3);
    load[3] = 1'b0; lv[3] = 2'd0;
    chk_word(3, "t4.w0", 1'b1, 2'd2);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_word(3, $sformatf("t4.w%0d", i), 1'b1, 2'd2);
    end
    stop[3] = 1'b1;
    tick();
    stop[3] = 1'b0;
    chk_word(3, "t4.stop", 1'b0, 2'd0);
    chk("t4.busy_drain", 32'(busy[3]), 1);
    tick();
    chk("t4.done", 32'(done[3]), 1);
    chk("t4.busy_end", 32'(busy[3]), 0);
    pulse_start(3);
    chk_word(3, "t4.seed_kept", 1'b1, 2'd2);
    stop[3] = 1'b1;
    tick();
    stop[3] = 1'b0;
    tick();
    chk("t4.done2", 32'(done[3]), 1);

    // 5: loaded seed, reset mid-burst restores VALUE and suppresses done
    load[0] = 1'b1; lv[0] = 2'd3;
    tick();
    load[0] = 1'b0; lv[0] = 2'd0;
    pulse_start(0);
    chk_word(0, "t5.loaded", 1'b1, 2'd3);
    tick();
    chk_word(0, "t5.w1", 1'b1, 2'd3);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk_word(0, "t5.rst", 1'b0, 2'd0);
    chk("t5.rst_O", 32'(o[0]), 0);
    chk("t5.rst_busy", 32'(busy[0]), 0);
    chk("t5.rst_done", 32'(done[0]), 0);
    tick();
    chk("t5.no_done", 32'(done[0]), 0);
    pulse_start(0);
    chk_word(0, "t5.value", 1'b1, 2'd1);
    begin
      int n;
      n = 0;
      while (!done[0] && n < 20) begin
        tick();
        n++;
      end
      chk("t5.done_wait", 32'(done[0]), 1);
    end

    // 6: start/load while busy are ignored
    tick();
    pulse_start(1);
    chk_word(1, "t6.w0", 1'b1, 2'd3);
    load[1] = 1'b1; lv[1] = 2'd1; start[1] = 1'b1;
    tick();
    load[1] = 1'b0; lv[1] = 2'd0; start[1] = 1'b0;
    chk_word(1, "t6.w1", 1'b1, 2'd0);
    tick(); chk_word(1, "t6.w2", 1'b1, 2'd1);
    tick();
    chk_word(1, "t6.end", 1'b0, 2'd0);
    chk("t6.done", 32'(done[1]), 1);
    pulse_start(1);
    chk_word(1, "t6.seed_same", 1'b1, 2'd3);
    tick(); chk_word(1, "t6.s1", 1'b1, 2'd0);
    tick(); chk_word(1, "t6.s2", 1'b1, 2'd1);
    tick(); chk("t6.done2", 32'(done[1]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
